// File: rtl/atomik_uart_pkg.sv
// Shared definitions for the ATOMiK 64-bit UART pair: byte-FSM state codes,
// word geometry and the bit-period helper.
package atomik_uart_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    localparam int BYTES_PER_WORD = 8;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchronizer, mid-bit sampling FSM and framing check.
// byte_done and start_accepted are same-cycle strobes for the word assembler.
module uart_rx_byte
    import atomik_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_line,
    output logic [7:0] byte_data,
    output logic       byte_done,
    output logic       start_accepted,
    output logic       fsm_idle,
    output logic       rx_busy,
    output logic       frame_error
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT + 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [1:0]       warm_reg;
    logic             armed_reg;
    logic [2:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_reg;
    logic [7:0]       shift_reg;
    logic             busy_reg;
    logic             fe_reg;

    logic line;
    logic ready;
    logic half_tick;
    logic bit_tick;

    assign line      = sync2_reg;
    // The synchronizer holds reset values for two edges after release.
    assign ready     = (warm_reg == 2'd2);
    assign half_tick = (cnt_reg == CNT_W'(HALF_BIT - 1));
    assign bit_tick  = (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

    assign fsm_idle       = (state_reg == ST_IDLE);
    assign start_accepted = fsm_idle && ready && armed_reg && !line;
    assign byte_done      = (state_reg == ST_STOP) && bit_tick && line;
    assign byte_data      = shift_reg;
    assign rx_busy        = busy_reg;
    assign frame_error    = fe_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            warm_reg  <= 2'd0;
            armed_reg <= 1'b1;
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= 3'd0;
            shift_reg <= 8'd0;
            busy_reg  <= 1'b0;
            fe_reg    <= 1'b0;
        end else begin
            sync1_reg <= rx_line;
            sync2_reg <= sync1_reg;
            fe_reg    <= 1'b0;
            if (warm_reg != 2'd2)
                warm_reg <= warm_reg + 2'd1;
            // First genuine line sample after reset: a low line must not start a byte.
            if (warm_reg == 2'd1)
                armed_reg <= sync1_reg;

            case (state_reg)
                ST_IDLE: begin
                    if (ready && !line) begin
                        if (armed_reg) begin
                            state_reg <= ST_START;
                            cnt_reg   <= '0;
                            busy_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_WAIT_HIGH;
                        end
                    end
                end
                ST_START: begin
                    if (half_tick) begin
                        cnt_reg <= '0;
                        if (!line) begin
                            state_reg <= ST_DATA;
                            bit_reg   <= 3'd0;
                        end else begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        cnt_reg   <= '0;
                        shift_reg <= {line, shift_reg[7:1]};
                        if (bit_reg == 3'd7)
                            state_reg <= ST_STOP;
                        else
                            bit_reg <= bit_reg + 3'd1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        cnt_reg  <= '0;
                        busy_reg <= 1'b0;
                        if (line) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            fe_reg    <= 1'b1;
                            state_reg <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (line) begin
                        state_reg <= ST_IDLE;
                        armed_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_64.sv
// Reassembles eight received bytes (first byte in the MSBs) into a 64-bit word
// and discards partial words after an inter-byte idle timeout.
module uart_rx_64
    import atomik_uart_pkg::*;
#(
    parameter int CLK_FREQ     = 27_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_line,
    output logic [63:0] data_out,
    output logic        data_valid,
    output logic        rx_busy,
    output logic        frame_error,
    output logic        timeout_error
);

    localparam int CLKS_PER_BIT   = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TCNT_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    logic [7:0] byte_data;
    logic       byte_done;
    logic       start_accepted;
    logic       fsm_idle;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_line        (rx_line),
        .byte_data      (byte_data),
        .byte_done      (byte_done),
        .start_accepted (start_accepted),
        .fsm_idle       (fsm_idle),
        .rx_busy        (rx_busy),
        .frame_error    (frame_error)
    );

    logic [IDX_W-1:0]  idx_reg;
    logic [TCNT_W-1:0] idle_cnt_reg;
    logic [63:0]       data_out_reg;
    logic              valid_reg;
    logic              timeout_reg;
    logic [7:0]        lane_reg [0:BYTES_PER_WORD-2];
    logic [63:0]       word_next;
    logic              timeout_hit;
    logic              last_byte;

    assign timeout_hit = fsm_idle && (idx_reg != '0) &&
                         (idle_cnt_reg == TCNT_W'(TIMEOUT_CYCLES - 1));
    assign last_byte   = (idx_reg == IDX_W'(BYTES_PER_WORD - 1));

    // Bytes 0..6 park in lanes; the eighth byte goes straight into data_out.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (!rst_n)
                    lane_reg[gi] <= 8'd0;
                else if (byte_done && idx_reg == IDX_W'(gi))
                    lane_reg[gi] <= byte_data;
            end
            assign word_next[(BYTES_PER_WORD - 1 - gi) * 8 +: 8] = lane_reg[gi];
        end
    endgenerate
    assign word_next[7:0] = byte_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_reg      <= '0;
            idle_cnt_reg <= '0;
            data_out_reg <= 64'd0;
            valid_reg    <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;

            // Timeout beats a coincident start edge, so that byte opens a fresh word.
            if (timeout_hit) begin
                timeout_reg  <= 1'b1;
                idx_reg      <= '0;
                idle_cnt_reg <= '0;
            end else if (start_accepted) begin
                idle_cnt_reg <= '0;
            end else if (fsm_idle && idx_reg != '0) begin
                idle_cnt_reg <= idle_cnt_reg + 1'b1;
            end

            if (frame_error) begin
                idx_reg <= '0;
            end else if (byte_done) begin
                if (last_byte) begin
                    data_out_reg <= word_next;
                    valid_reg    <= 1'b1;
                    idx_reg      <= '0;
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
        end
    end

    assign data_out      = data_out_reg;
    assign data_valid    = valid_reg;
    assign timeout_error = timeout_reg;

endmodule

// File: doc/uart_rx_64.md
Name: uart_rx_64

Overview:
Receives 8N1 serial bytes on a single line and reassembles each group of 8 bytes into one 64-bit word. It is the receive-side counterpart of the 64-bit UART transmitter. It is used on host-loopback and board-to-board test builds to capture the packed motif/delta words that the ATOMiK top level emits. It presents each completed word with a one-cycle valid pulse and reports framing and inter-byte timeout errors.

Parameters:
CLK_FREQ, 27_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer truncation; 234 at defaults)
TIMEOUT_BITS, 20, idle bit-periods allowed between bytes of one word before the partial word is discarded

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
rx_line  in  1  asynchronous serial input, idle high
data_out  out  64  last completed word; first received byte lands in [63:56], eighth byte in [7:0]
data_valid  out  1  one-cycle pulse when data_out is updated
rx_busy  out  1  high from accepted start edge until stop-bit sample
frame_error  out  1  one-cycle pulse on a bad stop bit
timeout_error  out  1  one-cycle pulse when a partial word is discarded on idle timeout

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. All flops are sampled on posedge clk and cleared when rst_n==0 at that edge.
- Reset values:
  - data_out=0, data_valid=0, rx_busy=0, frame_error=0, timeout_error=0.
  - Synchronizer flops reset to 1.
  - byte index=0, FSM=IDLE, armed=1.
- Input conditioning: rx_line passes through a 2-FF synchronizer. Every reference to the "line" below means the synchronized value.
- Byte FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when armed and line==0, go to START, clear the baud counter, and set rx_busy=1.
  - START: count CLKS_PER_BIT/2 cycles (117), then check the line.
    - Line==0: go to DATA, clear the bit index.
    - Line==1 (glitch): return to IDLE, set rx_busy=0, raise no error.
  - DATA: sample every CLKS_PER_BIT cycles. Bits arrive LSB first into the byte shift register. After the 8th sample, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles and set rx_busy=0.
    - Line==1: the byte is good; shift it into the word register and go to IDLE.
    - Line==0: pulse frame_error, reset the byte index to 0 (partial word dropped), go to WAIT_HIGH.
  - WAIT_HIGH: remain here until line==1, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 bytes.
- Word assembly:
  - Each good byte is written at byte index k into bits [63-8k -: 8]. The index then increments.
  - On the 8th good byte (k==7), data_out loads the full word on the cycle after the stop sample. data_valid pulses for exactly that one cycle, and the index wraps to 0.
  - data_out holds its value until the next completed word. There is no backpressure; the consumer must latch the word on data_valid.
- Timeout:
  - The idle counter runs only in IDLE with byte index != 0.
  - When it reaches TIMEOUT_BITS*CLKS_PER_BIT cycles, pulse timeout_error and clear the byte index.
  - The counter clears on any start edge accepted into START.
- Simultaneous events:
  - A start edge on the same cycle as timeout expiry: the timeout wins, the index clears, and the new byte becomes byte 0 of a fresh word.
  - frame_error and data_valid can never coincide.
- Tolerance: a byte is received correctly with transmitter rate error up to ±2%.
- Latency: the 8th stop-bit sample point to data_valid is 1 clk.
- Reset mid-operation: reset abandons any byte or word in progress. After release, the block needs a full idle-high line followed by a start edge; a line already low at release is held in WAIT_HIGH (armed behaviour).

Decomposition:
- Shared package atomik_uart_pkg holds:
  - FSM state encodings (shared with the transmitter)
  - BYTES_PER_WORD=8
  - a clks_per_bit(CLK_FREQ,BAUD_RATE) function
- One sub-module, uart_rx_byte, contains the synchronizer, the byte FSM, and the frame_error output. uart_rx_64 wraps it and adds word assembly and the timeout logic.

Test Plan:
1. Send bytes 01 23 45 67 89 AB CD EF at 234 clk/bit. Required response: data_out=64'h0123456789ABCDEF, a single data_valid pulse 1 clk after the 8th stop sample, no error pulses.
2. Drive rx_line low for 50 clks, then high. Required response: no byte, rx_busy drops at clk ~119, no frame_error, byte index still 0.
3. Corrupt the stop bit of byte 3 (drive 0), then release. Required response: frame_error pulses once, no data_valid. A following word FF 00 FF 00 FF 00 FF 00 yields 64'hFF00FF00FF00FF00.
4. Send 5 bytes, then idle for 20*234 clks. Required response: timeout_error pulses once. A following 8-byte word 11..88 yields 64'h1122334455667788.
5. Assert rst_n=0 for 2 clks during data bit 4 of byte 2. Required response: all outputs are 0. The next clean word DEADBEEFCAFEF00D is received exactly.
6. Send two words back-to-back with no idle gap. Required response: two data_valid pulses 80 bit-periods apart, and data_out holds word 1 until word 2 loads.
